link_bringup_mon: RTL
=====================

LINK_BRINGUP_MON -- requirements
Module: link_bringup_mon

Interface
REQ-001 Parameter NUM_LANES, default 4, number of monitored lanes; legal range 1..8.
REQ-002 Parameter TIMEOUT_W, default 21. A phase times out after 2^(TIMEOUT_W-1) dclk cycles.
REQ-003 Parameter STABLE_CYC, default 64. All lanes must hold block lock for this many consecutive cycles before the link is declared up.
REQ-004 Parameter MAX_RETRY, default 3. Maximum automatic retries; used only under REQ-024.
REQ-005 dclk  in  1  clock; reset sys_reset, asynchronous, active-low; clock dclk.
REQ-006 sys_reset  in  1  asynchronous active-low reset.
REQ-007 gt_locked  in  NUM_LANES  per-lane GT lock; asynchronous to dclk.
REQ-008 block_lock  in  NUM_LANES  per-lane PCS block lock; asynchronous to dclk.
REQ-009 restart  in  1  single-cycle request to restart bring-up.
REQ-010 state  out  3  FSM state: 0 RST, 1 WAIT_GT, 2 WAIT_BLK, 3 SETTLE, 4 LINKED, 5 FAIL.
REQ-011 completion_status  out  5  result code, per REQ-019.
REQ-012 gen_restart  out  1  one-cycle pulse telling the traffic generator to restart.
REQ-013 lane_lock_mask  out  NUM_LANES  synchronised block_lock value.
REQ-014 lock_loss_cnt  out  16  saturating count of lock-loss events seen in LINKED.
REQ-015 retry_cnt  out  2  number of automatic retries taken.

Function
REQ-016 gt_locked and block_lock SHALL each pass through a 2-flop synchroniser; every decision uses the synchronised values, giving 2-cycle input latency.
REQ-017 The phase timeout counter SHALL clear on every state change and every restart; it increments each cycle in WAIT_GT, WAIT_BLK and SETTLE.
REQ-018 FSM transitions SHALL be:
- RST->WAIT_GT on the first clock after reset release.
- WAIT_GT->WAIT_BLK when all gt_locked are set; WAIT_GT->FAIL on timeout.
- WAIT_BLK->SETTLE when all block_lock are set; WAIT_BLK->FAIL on timeout.
- SETTLE->LINKED after STABLE_CYC consecutive cycles with all lanes locked. Any lane drop returns to WAIT_BLK with the counters cleared.
- LINKED->FAIL when any lane's block_lock or gt_locked deasserts.
- FAIL holds until restart, or until REQ-024 applies.
REQ-019 completion_status SHALL take these values:
- 31 in RST.
- 0 in WAIT_GT, WAIT_BLK and SETTLE.
- 1 in LINKED.
- 10 for a GT lock timeout.
- 2 for a WAIT_BLK timeout with no lane locked.
- 3 for a WAIT_BLK timeout with some but not all lanes locked.
- 4 for a loss of lock from LINKED.
The value is registered and becomes valid in the same cycle the state becomes valid.
REQ-020 restart SHALL, from any non-RST state, move to WAIT_GT on the next cycle, clear retry_cnt, and pulse gen_restart for exactly one cycle. restart wins over a simultaneous timeout or lock change.
REQ-021 gen_restart SHALL also pulse once on every SETTLE->LINKED transition.
REQ-022 lock_loss_cnt SHALL increment on each LINKED->FAIL transition and saturate at 0xFFFF; restart does not clear it.

Reset
REQ-023 While sys_reset is low, every output SHALL take its reset value:
- state=0
- completion_status=31
- gen_restart=0
- lane_lock_mask=0
- lock_loss_cnt=0
- retry_cnt=0
- synchronisers and counters cleared
Assertion takes effect immediately, including mid-operation.

Configuration
REQ-024 With macro LINK_MON_AUTO_RETRY_EN defined, FAIL SHALL wait one full timeout period. If retry_cnt<MAX_RETRY, it then increments retry_cnt, moves to WAIT_GT and pulses gen_restart. Otherwise it stays in FAIL.
REQ-025 Without LINK_MON_AUTO_RETRY_EN, FAIL SHALL hold until restart, and retry_cnt SHALL be constant 0.

Verification
REQ-026 All four lanes assert gt_locked at cycle 10 and block_lock at cycle 50, with TIMEOUT_W=8 and STABLE_CYC=64 -> LINKED and status 1 at cycle 116±1, with a single gen_restart pulse.
REQ-027 gt_locked never asserts, TIMEOUT_W=8 -> FAIL with status 10 after 128 cycles in WAIT_GT.
REQ-028 Only lane 2 is block locked in WAIT_BLK until timeout -> status 3. With no lanes locked -> status 2.
REQ-029 Lane 0 block_lock drops for 1 cycle during SETTLE -> return to WAIT_BLK, no FAIL. The same drop in LINKED -> FAIL, status 4, lock_loss_cnt=1.
REQ-030 restart asserted in the same cycle as a WAIT_GT timeout -> WAIT_GT with status 0 and one gen_restart pulse. sys_reset asserted in LINKED -> status 31 immediately.
REQ-031 With LINK_MON_AUTO_RETRY_EN and GT lock absent -> exactly 3 retries (retry_cnt=3), then a permanent FAIL with status 10.

Source files
------------

// File: rtl/link_bringup_mon.sv
// Multi-lane link bring-up monitor: synchronises per-lane GT/block lock and walks the
// RST -> WAIT_GT -> WAIT_BLK -> SETTLE -> LINKED bring-up, with FAIL on timeout or lock loss.
// Optional automatic retry from FAIL is enabled by defining LINK_MON_AUTO_RETRY_EN.

module link_lane_sync (
  input  logic dclk,
  input  logic sys_reset,
  input  logic gt_async,
  input  logic blk_async,
  output logic gt_sync,
  output logic blk_sync
);
  logic [1:0] gt_ff, blk_ff;

  always_ff @(posedge dclk or negedge sys_reset) begin
    if (!sys_reset) begin
      gt_ff  <= '0;
      blk_ff <= '0;
    end else begin
      gt_ff  <= {gt_ff[0], gt_async};
      blk_ff <= {blk_ff[0], blk_async};
    end
  end

  assign gt_sync  = gt_ff[1];
  assign blk_sync = blk_ff[1];
endmodule

module link_bringup_mon #(
  parameter int NUM_LANES  = 4,
  parameter int TIMEOUT_W  = 21,
  parameter int STABLE_CYC = 64,
  parameter int MAX_RETRY  = 3
) (
  input  logic                 dclk,
  input  logic                 sys_reset,
  input  logic [NUM_LANES-1:0] gt_locked,
  input  logic [NUM_LANES-1:0] block_lock,
  input  logic                 restart,
  output logic [2:0]           state,
  output logic [4:0]           completion_status,
  output logic                 gen_restart,
  output logic [NUM_LANES-1:0] lane_lock_mask,
  output logic [15:0]          lock_loss_cnt,
  output logic [1:0]           retry_cnt
);
  typedef enum logic [2:0] {
    S_RST      = 3'd0,
    S_WAIT_GT  = 3'd1,
    S_WAIT_BLK = 3'd2,
    S_SETTLE   = 3'd3,
    S_LINKED   = 3'd4,
    S_FAIL     = 3'd5
  } state_t;

`ifdef LINK_MON_AUTO_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  localparam logic [TIMEOUT_W-1:0] TMO_LAST    = TIMEOUT_W'((1 << (TIMEOUT_W-1)) - 1);
  localparam logic [TIMEOUT_W-1:0] STABLE_LAST = TIMEOUT_W'(STABLE_CYC - 1);
  localparam logic [1:0]           RETRY_MAX   = 2'(MAX_RETRY);

  logic [NUM_LANES-1:0] gt_s, blk_s;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    link_lane_sync u_sync (
      .dclk      (dclk),
      .sys_reset (sys_reset),
      .gt_async  (gt_locked[i]),
      .blk_async (block_lock[i]),
      .gt_sync   (gt_s[i]),
      .blk_sync  (blk_s[i])
    );
  end

  state_t               st;
  logic [TIMEOUT_W-1:0] tmo_cnt;
  logic [1:0]           retry_q;
  logic                 all_gt, all_blk, tmo;

  assign all_gt  = &gt_s;
  assign all_blk = &blk_s;
  // The phase counter doubles as the SETTLE stability counter since it clears on entry.
  assign tmo     = (tmo_cnt == TMO_LAST);

  always_ff @(posedge dclk or negedge sys_reset) begin
    if (!sys_reset) begin
      st                <= S_RST;
      completion_status <= 5'd31;
      gen_restart       <= 1'b0;
      lock_loss_cnt     <= '0;
      retry_q           <= '0;
      tmo_cnt           <= '0;
    end else begin
      gen_restart <= 1'b0;
      tmo_cnt     <= tmo_cnt + TIMEOUT_W'(1);
      if (st == S_RST) begin
        st                <= S_WAIT_GT;
        completion_status <= 5'd0;
        tmo_cnt           <= '0;
      end else if (restart) begin
        // Restart outranks any timeout or lock change seen in the same cycle.
        st                <= S_WAIT_GT;
        completion_status <= 5'd0;
        gen_restart       <= 1'b1;
        retry_q           <= '0;
        tmo_cnt           <= '0;
      end else begin
        case (st)
          S_WAIT_GT:
            if (all_gt) begin
              st      <= S_WAIT_BLK;
              tmo_cnt <= '0;
            end else if (tmo) begin
              st                <= S_FAIL;
              completion_status <= 5'd10;
              tmo_cnt           <= '0;
            end
          S_WAIT_BLK:
            if (all_blk) begin
              st      <= S_SETTLE;
              tmo_cnt <= '0;
            end else if (tmo) begin
              st                <= S_FAIL;
              completion_status <= (blk_s == '0) ? 5'd2 : 5'd3;
              tmo_cnt           <= '0;
            end
          S_SETTLE:
            if (!(all_gt && all_blk)) begin
              st      <= S_WAIT_BLK;
              tmo_cnt <= '0;
            end else if (tmo_cnt == STABLE_LAST) begin
              st                <= S_LINKED;
              completion_status <= 5'd1;
              gen_restart       <= 1'b1;
              tmo_cnt           <= '0;
            end
          S_LINKED: begin
            tmo_cnt <= '0;
            if (!(all_gt && all_blk)) begin
              st                <= S_FAIL;
              completion_status <= 5'd4;
              if (lock_loss_cnt != 16'hFFFF) lock_loss_cnt <= lock_loss_cnt + 16'd1;
            end
          end
          S_FAIL:
            if (!RETRY_EN) begin
              tmo_cnt <= '0;
            end else if (tmo && (retry_q < RETRY_MAX)) begin
              st                <= S_WAIT_GT;
              completion_status <= 5'd0;
              gen_restart       <= 1'b1;
              retry_q           <= retry_q + 2'd1;
              tmo_cnt           <= '0;
            end
          default: st <= S_RST;
        endcase
      end
    end
  end

  assign state          = st;
  assign lane_lock_mask = blk_s;
  assign retry_cnt      = retry_q;
endmodule
